// File: rtl/alu_top.sv
// Registered 4-function ALU.
//   op 00: signed subtract A - B
//   op 01: bitwise NAND
//   op 10: leading-ones count of {i_arg0, i_arg1}
//   op 11: one-hot to binary decode of {i_arg1, i_arg0}
// Ports:
//   i_clk    - clock, rising edge active
//   i_rstn   - asynchronous active-low reset
//   i_arg0   - operand A (signed, LEN bits)
//   i_arg1   - operand B (signed, LEN bits)
//   i_oper   - operation select
//   o_result - registered result (signed, WIDTH bits)
//   o_flag   - registered status {OVERFLOW, POS, NEG, ERR}
// Only WIDTH == LEN is supported.
module alu_top #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEN   = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [LEN-1:0]   i_arg0,
  input  logic [LEN-1:0]   i_arg1,
  input  logic [1:0]       i_oper,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flag
);

  // Largest value representable as a positive signed WIDTH-bit number.
  localparam int unsigned MaxPos = (2 ** (WIDTH - 1)) - 1;

  localparam logic [1:0] OpSub  = 2'b00;
  localparam logic [1:0] OpNand = 2'b01;
  localparam logic [1:0] OpLone = 2'b10;
  localparam logic [1:0] OpDec  = 2'b11;

  logic [WIDTH-1:0] result_d, result_q;
  logic [3:0]       flag_d, flag_q;

  logic [WIDTH-1:0] diff;
  logic [2*LEN-1:0] cnt_vec;
  logic [2*LEN-1:0] dec_vec;
  logic [31:0]      lone_cnt;
  logic [31:0]      set_cnt;
  logic [31:0]      set_idx;
  logic             run;
  logic             err;
  logic             ovf;

  // Leading-ones count: stop counting at the first zero below the MSB.
  always_comb begin
    cnt_vec  = {i_arg0, i_arg1};
    lone_cnt = '0;
    run      = 1'b1;
    for (int i = 2 * LEN - 1; i >= 0; i--) begin
      if (run && cnt_vec[i]) begin
        lone_cnt = lone_cnt + 32'd1;
      end else begin
        run = 1'b0;
      end
    end
  end

  // One-hot decode: count set bits and remember the position of the last one seen.
  always_comb begin
    dec_vec = {i_arg1, i_arg0};
    set_cnt = '0;
    set_idx = '0;
    for (int i = 0; i < 2 * LEN; i++) begin
      if (dec_vec[i]) begin
        set_cnt = set_cnt + 32'd1;
        set_idx = 32'(i);
      end
    end
  end

  always_comb begin
    diff     = i_arg0 - i_arg1;
    result_d = '0;
    err      = 1'b0;
    ovf      = 1'b0;
    unique case (i_oper)
      OpSub: begin
        result_d = diff;
        // Overflow only possible when operand signs differ.
        ovf = (i_arg0[LEN-1] != i_arg1[LEN-1]) && (diff[WIDTH-1] != i_arg0[LEN-1]);
      end
      OpNand: begin
        result_d = ~(i_arg0 & i_arg1);
      end
      OpLone: begin
        result_d = lone_cnt[WIDTH-1:0];
        ovf      = lone_cnt > MaxPos;
      end
      OpDec: begin
        if (set_cnt == 32'd1) begin
          result_d = set_idx[WIDTH-1:0];
          ovf      = set_idx > MaxPos;
        end else begin
          err = 1'b1;
        end
      end
      default: begin
        result_d = '0;
      end
    endcase
    // NEG/POS come from the final truncated result.
    flag_d = {ovf,
              (result_d != '0) && !result_d[WIDTH-1],
              result_d[WIDTH-1],
              err};
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      result_q <= '0;
      flag_q   <= '0;
    end else begin
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign o_result = result_q;
  assign o_flag   = flag_q;

endmodule

// File: tb/tb_alu_top.sv
module tb_alu_top;

  logic       clk;
  logic       rstn;
  logic [3:0] arg0;
  logic [3:0] arg1;
  logic [1:0] oper;
  logic [3:0] result;
  logic [3:0] flag;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_res = '0;
  logic [3:0] exp_flag = '0;

  alu_top #(.WIDTH(4), .LEN(4)) dut (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_arg0  (arg0),
    .i_arg1  (arg1),
    .i_oper  (oper),
    .o_result(result),
    .o_flag  (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model from the arithmetic definition; returns {flag, result}.
  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] op);
    int         d;
    int         cnt;
    logic [7:0] v;
    logic [3:0] r;
    logic       ovf;
    logic       err;
    r   = '0;
    ovf = 1'b0;
    err = 1'b0;
    case (op)
      2'b00: begin
        d   = int'($signed(a)) - int'($signed(b));
        ovf = (d < -8) || (d > 7);
        r   = 4'(d);
      end
      2'b01: r = ~(a & b);
      2'b10: begin
        v   = {a, b};
        cnt = 0;
        while (cnt < 8 && v[7 - cnt]) cnt++;
        ovf = cnt > 7;
        r   = 4'(cnt);
      end
      default: begin
        v = {b, a};
        if ($countones(v) == 1) begin
          r   = 4'($clog2(v));
          ovf = $clog2(v) > 7;
        end else begin
          err = 1'b1;
        end
      end
    endcase
    return {ovf, (r != 0) && !r[3], r[3], err, r};
  endfunction

  task automatic check(input string name, input logic [3:0] got_r, input logic [3:0] want_r,
                       input logic [3:0] got_f, input logic [3:0] want_f);
    checks++;
    if (got_r !== want_r || got_f !== want_f) begin
      errors++;
      $display("FAIL %s: result=%b flag=%b, required result=%b flag=%b",
               name, got_r, got_f, want_r, want_f);
    end
  endtask

  // Reference pipeline stage: one cycle of latency, cleared by reset.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_res  <= '0;
      exp_flag <= '0;
    end else begin
      logic [7:0] m;
      m = model(arg0, arg1, oper);
      exp_res  <= m[3:0];
      exp_flag <= m[7:4];
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    check("model", result, exp_res, flag, exp_flag);
  end

  // Drive one operation and check the registered outputs one edge later.
  task automatic apply(input string name, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op, input logic [3:0] want_r,
                       input logic [3:0] want_f);
    arg0 = a;
    arg1 = b;
    oper = op;
    @(posedge clk);
    #1;
    check(name, result, want_r, flag, want_f);
  endtask

  initial begin
    rstn = 1'b0;
    arg0 = 4'h7;
    arg1 = 4'h3;
    oper = 2'b00;
    // Inputs toggle while reset is held; outputs must stay cleared.
    for (int i = 0; i < 3; i++) begin
      #5;
      arg0 = ~arg0;
      oper = oper + 2'b01;
    end
    check("reset_hold", result, 4'h0, flag, 4'h0);
    #2;
    rstn = 1'b1; // released at t=17, before the edge at t=25
    #4;
    check("reset_release", result, 4'h0, flag, 4'h0);

    // Subtract
    apply("sub_7_3",      4'd7,    4'd3,    2'b00, 4'd4,    4'b0100);
    apply("sub_m8_1",     4'b1000, 4'd1,    2'b00, 4'd7,    4'b1100);
    apply("sub_zero",     4'd5,    4'd5,    2'b00, 4'd0,    4'b0000);
    apply("sub_neg",      4'd1,    4'd3,    2'b00, 4'b1110, 4'b0010);
    apply("sub_ovf_neg",  4'd7,    4'b1111, 2'b00, 4'b1000, 4'b1010);
    // NAND
    apply("nand_f_1",     4'b1111, 4'b0001, 2'b01, 4'b1110, 4'b0010);
    apply("nand_0_0",     4'b0000, 4'b0000, 2'b01, 4'b1111, 4'b0010);
    apply("nand_f_f",     4'b1111, 4'b1111, 2'b01, 4'b0000, 4'b0000);
    // Leading ones
    apply("lone_c_f",     4'b1100, 4'b1111, 2'b10, 4'd2,    4'b0100);
    apply("lone_all",     4'b1111, 4'b1111, 2'b10, 4'b1000, 4'b1010);
    apply("lone_msb0",    4'b0111, 4'b1111, 2'b10, 4'd0,    4'b0000);
    apply("lone_7",       4'b1111, 4'b1110, 2'b10, 4'd7,    4'b0100);
    // One-hot decode
    apply("dec_idx6",     4'b0000, 4'b0100, 2'b11, 4'd6,    4'b0100);
    apply("dec_idx0",     4'b0001, 4'b0000, 2'b11, 4'd0,    4'b0000);
    apply("dec_two",      4'b0011, 4'b0000, 2'b11, 4'd0,    4'b0001);
    apply("dec_zero",     4'b0000, 4'b0000, 2'b11, 4'd0,    4'b0001);
    apply("dec_idx7",     4'b0000, 4'b1000, 2'b11, 4'd7,    4'b0100);
    apply("dec_idx3",     4'b1000, 4'b0000, 2'b11, 4'd3,    4'b0100);

    // Back-to-back pseudo-random traffic, checked by the model every cycle.
    for (int i = 0; i < 200; i++) begin
      arg0 = 4'($urandom);
      arg1 = 4'($urandom);
      oper = 2'($urandom);
      @(posedge clk);
      #1;
    end

    // Mid-stream reset: clears immediately, in-flight op discarded.
    apply("pre_reset",    4'd7,    4'd3,    2'b00, 4'd4,    4'b0100);
    arg0 = 4'b1111;
    arg1 = 4'b1111;
    oper = 2'b10;
    rstn = 1'b0;
    #1;
    check("async_reset", result, 4'h0, flag, 4'h0);
    @(posedge clk);
    #1;
    check("reset_edge", result, 4'h0, flag, 4'h0);
    #2;
    rstn = 1'b1;
    apply("post_reset",   4'b1111, 4'b0001, 2'b01, 4'b1110, 4'b0010);
    apply("post_reset2",  4'd2,    4'd1,    2'b00, 4'd1,    4'b0100);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
